// File: rtl/hub75_scan_ctrl.sv
// HUB75 BCM scan engine: reads pixel pairs from frame-buffer port B and shifts bit-planes out blanked, 4 clocks per column.
// Optional HUB75_E_LINE_EN adds the e row line (1/32 scan); en is only honoured in IDLE and at the end of a display period.
module hub75_scan_ctrl #(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 32,
  parameter int BPP       = 12,
  parameter int BPC       = 4,
  parameter int CHAINED   = 1,
  parameter int BASE_TIME = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  output logic [13:0]    addr_b,
  output logic           re_b,
  output logic           we_b,
  output logic [BPP-1:0] dat_in_b,
  input  logic [BPP-1:0] dat_out_b,
  output logic           sclk,
  output logic           lat,
  output logic           oe,
  output logic           a,
  output logic           b,
  output logic           c,
  output logic           d,
`ifdef HUB75_E_LINE_EN
  output logic           e,
`endif
  output logic           r0,
  output logic           g0,
  output logic           b0,
  output logic           r1,
  output logic           g1,
  output logic           b1,
  output logic           frame_start
);

  localparam int N         = WIDTH * CHAINED;
  localparam int SCAN_ROWS = HEIGHT / 2;
  localparam int CW        = (N > 1) ? $clog2(N) : 1;
  localparam int KW        = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int DCW       = $clog2((BASE_TIME << (BPC - 1)) + 1);
`ifdef HUB75_E_LINE_EN
  localparam int RW        = 5;
`else
  localparam int RW        = 4;
`endif

  typedef enum logic [2:0] {
    IDLE, RD_TOP, RD_BOT, LOAD, CLK, BLANK, LATCH, DISPLAY
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q;
  logic [KW-1:0]   plane_q;
  logic [RW-1:0]   row_q;
  logic [RW-1:0]   row_out_q;
  logic [DCW-1:0]  disp_q;
  logic [BPP-1:0]  top_px, bot_px, bot_src;
  logic [13:0]     top_addr, bot_addr;
  logic [DCW-1:0]  plane_time;
  logic            col_last, plane_last, row_last, disp_last;
  logic [RW-1:0]   row_sel;

  assign col_last   = (col_q == CW'(N - 1));
  assign plane_last = (plane_q == KW'(BPC - 1));
  assign row_last   = (row_q == RW'(SCAN_ROWS - 1));
  assign plane_time = DCW'(BASE_TIME) << plane_q;
  assign disp_last  = (disp_q == plane_time - DCW'(1));

  assign top_addr = 14'(row_q) * 14'(N) + 14'(col_q);
  assign bot_addr = (14'(row_q) + 14'(SCAN_ROWS)) * 14'(N) + 14'(col_q);

  assign we_b     = 1'b0;
  assign dat_in_b = '0;

  // Bottom pixel arrives during LOAD, so the pins see it straight from the buffer that cycle.
  assign bot_src = (state_q == LOAD) ? dat_out_b : bot_px;
  assign r0 = top_px[2*BPC + 32'(plane_q)];
  assign g0 = top_px[BPC + 32'(plane_q)];
  assign b0 = top_px[32'(plane_q)];
  assign r1 = bot_src[2*BPC + 32'(plane_q)];
  assign g1 = bot_src[BPC + 32'(plane_q)];
  assign b1 = bot_src[32'(plane_q)];

  // Row lines follow the counter only while latching, so they never move during display.
  assign row_sel = (state_q == LATCH) ? row_q : row_out_q;
  assign {d, c, b, a} = row_sel[3:0];
`ifdef HUB75_E_LINE_EN
  assign e = row_sel[4];
`endif

  always_comb begin
    state_d     = state_q;
    re_b        = 1'b0;
    addr_b      = '0;
    sclk        = 1'b0;
    lat         = 1'b0;
    oe          = 1'b1;
    frame_start = 1'b0;
    case (state_q)
      IDLE:    if (en) state_d = RD_TOP;
      RD_TOP: begin
        re_b        = 1'b1;
        addr_b      = top_addr;
        frame_start = (row_q == '0) && (plane_q == '0) && (col_q == '0);
        state_d     = RD_BOT;
      end
      RD_BOT: begin
        re_b    = 1'b1;
        addr_b  = bot_addr;
        state_d = LOAD;
      end
      LOAD:    state_d = CLK;
      CLK: begin
        sclk    = 1'b1;
        state_d = col_last ? BLANK : RD_TOP;
      end
      BLANK:   state_d = LATCH;
      LATCH: begin
        lat     = 1'b1;
        state_d = DISPLAY;
      end
      DISPLAY: begin
        oe = 1'b0;
        if (disp_last) state_d = en ? RD_TOP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      plane_q   <= '0;
      row_q     <= '0;
      row_out_q <= '0;
      disp_q    <= '0;
      top_px    <= '0;
      bot_px    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        RD_BOT: top_px <= dat_out_b;
        LOAD:   bot_px <= dat_out_b;
        CLK:    col_q  <= col_last ? '0 : col_q + CW'(1);
        LATCH:  row_out_q <= row_q;
        DISPLAY: begin
          if (disp_last) begin
            disp_q <= '0;
            col_q  <= '0;
            if (plane_last) begin
              plane_q <= '0;
              row_q   <= row_last ? '0 : row_q + RW'(1);
            end else begin
              plane_q <= plane_q + KW'(1);
            end
          end else begin
            disp_q <= disp_q + DCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl: 4x8 panel, BPC=4, BASE_TIME=2, preloaded frame buffer.
module tb_hub75_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [13:0] addr_b;
  logic        re_b, we_b;
  logic [11:0] dat_in_b;
  logic [11:0] dat_out_b = '0;
  logic        sclk, lat, oe, a, b, c, d;
  logic        r0, g0, b0, r1, g1, b1;
  logic        frame_start;
`ifdef HUB75_E_LINE_EN
  logic        e;
`endif

  int total = 0;
  int passed = 0;
  int ncyc = 0;
  int t0;
  logic [5:0] px;
  logic [11:0] mem [0:31];

  always #5 clk = ~clk;

  // Frame buffer port B with exactly one cycle of read latency.
  always @(posedge clk) if (re_b) dat_out_b <= mem[addr_b[4:0]];

  hub75_scan_ctrl #(
    .WIDTH(4), .HEIGHT(8), .BPP(12), .BPC(4), .CHAINED(1), .BASE_TIME(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .addr_b(addr_b), .re_b(re_b), .we_b(we_b), .dat_in_b(dat_in_b), .dat_out_b(dat_out_b),
    .sclk(sclk), .lat(lat), .oe(oe), .a(a), .b(b), .c(c), .d(d),
`ifdef HUB75_E_LINE_EN
    .e(e),
`endif
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .frame_start(frame_start)
  );

  task automatic step();
    @(negedge clk);
    ncyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Walks one plane starting at its RD_TOP cycle; returns rgb pins seen in LOAD of column 0.
  task automatic plane_walk(input int row, input int k, input int drop_at, output logic [5:0] px0);
    int sck;
    int dl;
    sck = 0;
    px0 = '0;
    for (int col = 0; col < 4; col++) begin
      if (col == drop_at) en = 1'b0;
      chk("addr_top", 32'(addr_b), row * 4 + col);
      chk("re_top", 32'(re_b), 1);
      step();
      chk("addr_bot", 32'(addr_b), (row + 4) * 4 + col);
      step();
      if (col == 0) px0 = {r0, g0, b0, r1, g1, b1};
      chk("load_sclk", 32'(sclk), 0);
      step();
      sck += int'(sclk);
      step();
    end
    chk("sclk_edges", sck, 4);
    chk("blank_oe", 32'(oe), 1);
    step();
    chk("lat", 32'(lat), 1);
    chk("lat_oe", 32'(oe), 1);
    chk("row_sel", 32'({d, c, b, a}), row);
    step();
    dl = 0;
    while (oe == 1'b0 && dl < 64) begin
      dl++;
      step();
    end
    chk("disp_len", dl, 2 << k);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 12'(i * 291);
    mem[0]  = 12'hA53;
    mem[16] = 12'h0F0;

    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rst_oe", 32'(oe), 1);
    chk("rst_lat", 32'(lat), 0);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_re", 32'(re_b), 0);
    chk("rst_addr", 32'(addr_b), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_rgb", 32'({r0, g0, b0, r1, g1, b1}), 0);
    chk("rst_row", 32'({d, c, b, a}), 0);
    chk("we_b", 32'(we_b), 0);
    chk("dat_in_b", 32'(dat_in_b), 0);

    rst = 1'b0;
    step();
    chk("first_fs", 32'(frame_start), 1);
    chk("first_addr", 32'(addr_b), 0);
    t0 = ncyc;

    // Full frame. 0xA53 / 0x0F0: plane0 -> r0=0 g0=1 b0=1 r1=0 g1=1 b1=0; plane3 -> 1,0,0,0,1,0.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        plane_walk(r, k, -1, px);
        if (r == 0 && k == 0) chk("px_plane0", 32'(px), 32'(6'b011010));
        if (r == 0 && k == 3) chk("px_plane3", 32'(px), 32'(6'b100010));
      end
    end
    chk("wrap_fs", 32'(frame_start), 1);
    chk("frame_period", ncyc - t0, 408);

    // Row wrap latches row 0; then drop en during plane 1 shifting.
    plane_walk(0, 0, -1, px);
    plane_walk(0, 1, 1, px);
    chk("idle_oe", 32'(oe), 1);
    chk("idle_re", 32'(re_b), 0);
    for (int i = 0; i < 3; i++) step();
    chk("idle_hold_re", 32'(re_b), 0);
    chk("idle_hold_oe", 32'(oe), 1);
    en = 1'b1;
    step();
    chk("resume_fs", 32'(frame_start), 0);
    plane_walk(0, 2, -1, px);

    // Reset during the plane-3 display period.
    for (int i = 0; i < 18; i++) step();
    chk("in_display_oe", 32'(oe), 0);
    rst = 1'b1;
    step();
    chk("rst_disp_oe", 32'(oe), 1);
    chk("rst_disp_re", 32'(re_b), 0);
    chk("rst_disp_rgb", 32'({r0, g0, b0, r1, g1, b1}), 0);
    rst = 1'b0;
    step();
    chk("restart_fs", 32'(frame_start), 1);
    chk("restart_addr", 32'(addr_b), 0);
    plane_walk(0, 0, -1, px);
    chk("restart_px", 32'(px), 32'(6'b011010));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
